// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
package rf_arb_pkg;

  localparam int unsigned RF_RAW = 4;
  localparam int unsigned RF_DW  = 8;

  typedef logic [RF_RAW-1:0] rf_addr_t;
  typedef logic [RF_DW-1:0]  rf_data_t;

  typedef struct packed {
    rf_addr_t addr;
    rf_data_t data;
  } wr_req_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } src_e;

  function automatic src_e other_src(input src_e s);
    return (s == SRC_ALU) ? SRC_LD : SRC_ALU;
  endfunction

endpackage

// File: rtl/rf_wr_slot.sv
// One-entry holding slot for a pending register-file write.
// A load on the same edge as a clear wins, so a draining slot can refill
// without a bubble.
module rf_wr_slot #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_d,
  output logic         o_valid,
  output logic [W-1:0] o_q
);

  // Capture on load, drop on clear; load takes priority over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_q     <= '0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_q     <= i_d;
    end else if (i_clear) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Two-source (ALU / load) arbiter onto the register file's single write port.
// Each source owns a one-entry slot; a round-robin pick drains the slots into
// a registered write port, except that same-address entries drain oldest first.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned RAW = RF_RAW,
  parameter int unsigned DW  = RF_DW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alu_req_i,
  input  logic [RAW-1:0]      alu_addr_i,
  input  logic [DW-1:0]       alu_data_i,
  output logic                alu_gnt_o,
  input  logic                ld_req_i,
  input  logic [RAW-1:0]      ld_addr_i,
  input  logic [DW-1:0]       ld_data_i,
  output logic                ld_gnt_o,
  output logic                wen_o,
  output logic [RAW-1:0]      waddr_o,
  output logic [DW-1:0]       wdata_o,
  output logic [(1<<RAW)-1:0] busy_o,
  output logic                idle_o
);

  localparam int unsigned NREG = 1 << RAW;

  typedef struct packed {
    logic [RAW-1:0] addr;
    logic [DW-1:0]  data;
  } slot_t;

  logic  w_alu_v, w_ld_v;
  slot_t w_alu_q, w_ld_q, w_alu_d, w_ld_d, w_win_q;
  logic  w_alu_acc, w_ld_acc, w_alu_win, w_ld_win, w_any;
  src_e  w_sel;
  src_e  r_last;
  logic  r_ld_older;

  assign w_alu_d = '{addr: alu_addr_i, data: alu_data_i};
  assign w_ld_d  = '{addr: ld_addr_i,  data: ld_data_i};

  rf_wr_slot #(.W($bits(slot_t))) u_alu_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_alu_acc),
    .i_clear (w_alu_win),
    .i_d     (w_alu_d),
    .o_valid (w_alu_v),
    .o_q     (w_alu_q)
  );

  rf_wr_slot #(.W($bits(slot_t))) u_ld_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_ld_acc),
    .i_clear (w_ld_win),
    .i_d     (w_ld_d),
    .o_valid (w_ld_v),
    .o_q     (w_ld_q)
  );

  // Pick the slot to issue: single valid wins, same-address goes oldest-first,
  // otherwise alternate away from the previous winner.
  always_comb begin
    w_any = w_alu_v | w_ld_v;
    w_sel = SRC_ALU;
    if (w_alu_v && w_ld_v) begin
      if (w_alu_q.addr == w_ld_q.addr) w_sel = r_ld_older ? SRC_LD : SRC_ALU;
      else                             w_sel = other_src(r_last);
    end else if (w_ld_v) begin
      w_sel = SRC_LD;
    end
    w_alu_win = w_any && (w_sel == SRC_ALU);
    w_ld_win  = w_any && (w_sel == SRC_LD);
    w_win_q   = (w_sel == SRC_LD) ? w_ld_q : w_alu_q;
  end

  assign alu_gnt_o = !w_alu_v || w_alu_win;
  assign ld_gnt_o  = !w_ld_v  || w_ld_win;
  assign w_alu_acc = alu_req_i && alu_gnt_o;
  assign w_ld_acc  = ld_req_i  && ld_gnt_o;

  // Age flag: set only when ALU accepts while an LD entry stays behind;
  // any other accept leaves ALU as the older (or tie-winning) entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_ld_older <= 1'b0;
    else if (w_alu_acc && w_ld_acc)    r_ld_older <= 1'b0;
    else if (w_alu_acc)                r_ld_older <= w_ld_v && !w_ld_win;
    else if (w_ld_acc)                 r_ld_older <= 1'b0;
  end

  // Registered write port; address/data hold when nothing issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_o   <= 1'b0;
      waddr_o <= '0;
      wdata_o <= '0;
      r_last  <= SRC_LD;
    end else if (w_any) begin
      wen_o   <= 1'b1;
      waddr_o <= w_win_q.addr;
      wdata_o <= w_win_q.data;
      r_last  <= w_sel;
    end else begin
      wen_o   <= 1'b0;
    end
  end

  // Busy decode covers both slots and the write currently on the port.
  always_comb begin
    busy_o = '0;
    if (w_alu_v) busy_o = busy_o | (NREG'(1) << w_alu_q.addr);
    if (w_ld_v)  busy_o = busy_o | (NREG'(1) << w_ld_q.addr);
    if (wen_o)   busy_o = busy_o | (NREG'(1) << waddr_o);
  end

  assign idle_o = !w_alu_v && !w_ld_v && !wen_o;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter.
module tb_rf_write_arbiter;
  import rf_arb_pkg::*;

  localparam int unsigned RAW = RF_RAW;
  localparam int unsigned DW  = RF_DW;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                alu_req_i, ld_req_i;
  logic [RAW-1:0]      alu_addr_i, ld_addr_i;
  logic [DW-1:0]       alu_data_i, ld_data_i;
  logic                alu_gnt_o, ld_gnt_o;
  logic                wen_o;
  logic [RAW-1:0]      waddr_o;
  logic [DW-1:0]       wdata_o;
  logic [(1<<RAW)-1:0] busy_o;
  logic                idle_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [RAW+DW-1:0] wq[$];
  int                wc[$];
  logic [DW-1:0]     rf_m [1<<RAW];

  rf_write_arbiter #(.RAW(RAW), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_req_i  (alu_req_i),
    .alu_addr_i (alu_addr_i),
    .alu_data_i (alu_data_i),
    .alu_gnt_o  (alu_gnt_o),
    .ld_req_i   (ld_req_i),
    .ld_addr_i  (ld_addr_i),
    .ld_data_i  (ld_data_i),
    .ld_gnt_o   (ld_gnt_o),
    .wen_o      (wen_o),
    .waddr_o    (waddr_o),
    .wdata_o    (wdata_o),
    .busy_o     (busy_o),
    .idle_o     (idle_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register-file model: records every write seen on the port.
  always @(negedge clk) begin
    if (rst_n && wen_o) begin
      wq.push_back({waddr_o, wdata_o});
      wc.push_back(cyc);
      rf_m[waddr_o] = wdata_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic idle_inputs();
    alu_req_i = 1'b0;
    ld_req_i  = 1'b0;
  endtask

  task automatic clear_q();
    wq.delete();
    wc.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int ai, li, k, cnt;
    logic ga, gl, both_low, prev_low;
    logic [RAW+DW-1:0] exp_w;

    alu_req_i = 0; ld_req_i = 0;
    alu_addr_i = '0; ld_addr_i = '0; alu_data_i = '0; ld_data_i = '0;
    for (int i = 0; i < (1<<RAW); i++) rf_m[i] = '0;
    do_reset();

    // Reset state
    chk("rst_wen",   wen_o,     0);
    chk("rst_waddr", waddr_o,   0);
    chk("rst_wdata", wdata_o,   0);
    chk("rst_busy",  busy_o,    0);
    chk("rst_idle",  idle_o,    1);
    chk("rst_agnt",  alu_gnt_o, 1);
    chk("rst_lgnt",  ld_gnt_o,  1);

    // Single ALU write: addr 3, data 0x5A
    alu_req_i = 1; alu_addr_i = 4'd3; alu_data_i = 8'h5A;
    tick();
    idle_inputs();
    chk("t1_e0_wen",  wen_o,  0);
    chk("t1_e0_busy", busy_o, 32'h0008);
    chk("t1_e0_idle", idle_o, 0);
    tick();
    chk("t1_e1_wen",   wen_o,   1);
    chk("t1_e1_waddr", waddr_o, 3);
    chk("t1_e1_wdata", wdata_o, 32'h5A);
    chk("t1_e1_busy",  busy_o,  32'h0008);
    tick();
    chk("t1_e2_wen",   wen_o,   0);
    chk("t1_e2_busy",  busy_o,  0);
    chk("t1_e2_idle",  idle_o,  1);
    chk("t1_e2_hold",  waddr_o, 3);

    // Same-edge pair, distinct addresses, fresh round-robin state
    do_reset();
    clear_q();
    alu_req_i = 1; alu_addr_i = 4'd2; alu_data_i = 8'h11;
    ld_req_i  = 1; ld_addr_i  = 4'd5; ld_data_i  = 8'h22;
    tick();
    idle_inputs();
    chk("t2_agnt", alu_gnt_o, 1);
    chk("t2_lgnt", ld_gnt_o,  0);
    chk("t2_busy", busy_o,    32'h0024);
    repeat (3) tick();
    chk("t2_n",   wq.size(), 2);
    chk("t2_w0",  wq[0], {4'd2, 8'h11});
    chk("t2_w1",  wq[1], {4'd5, 8'h22});
    chk("t2_b2b", wc[1] - wc[0], 1);

    // Lone ALU write leaves ALU as last winner; the next tie goes to LD
    alu_req_i = 1; alu_addr_i = 4'd9; alu_data_i = 8'h99;
    tick();
    idle_inputs();
    repeat (2) tick();
    clear_q();
    alu_req_i = 1; alu_addr_i = 4'd2; alu_data_i = 8'h33;
    ld_req_i  = 1; ld_addr_i  = 4'd5; ld_data_i  = 8'h44;
    tick();
    idle_inputs();
    repeat (3) tick();
    chk("t2b_n",  wq.size(), 2);
    chk("t2b_w0", wq[0], {4'd5, 8'h44});
    chk("t2b_w1", wq[1], {4'd2, 8'h33});

    // Same-address race: LD first, ALU one edge later
    clear_q();
    ld_req_i = 1; ld_addr_i = 4'd4; ld_data_i = 8'hAA;
    tick();
    ld_req_i = 0;
    alu_req_i = 1; alu_addr_i = 4'd4; alu_data_i = 8'hBB;
    tick();
    alu_req_i = 0;
    chk("t3_busy", busy_o, 32'h0010);
    repeat (2) tick();
    chk("t3_n",  wq.size(), 2);
    chk("t3_w0", wq[0], {4'd4, 8'hAA});
    chk("t3_w1", wq[1], {4'd4, 8'hBB});
    chk("t3_rf", rf_m[4], 32'hBB);

    // Same-edge same-address tie: ALU first even though ALU won last
    clear_q();
    alu_req_i = 1; alu_addr_i = 4'd7; alu_data_i = 8'h01;
    ld_req_i  = 1; ld_addr_i  = 4'd7; ld_data_i  = 8'h02;
    tick();
    idle_inputs();
    repeat (3) tick();
    chk("t4_n",  wq.size(), 2);
    chk("t4_w0", wq[0], {4'd7, 8'h01});
    chk("t4_w1", wq[1], {4'd7, 8'h02});
    chk("t4_rf", rf_m[7], 32'h02);

    // Saturation: both sources stream 4 items each
    clear_q();
    ai = 0; li = 0; cnt = 0; prev_low = 0;
    while ((ai < 4 || li < 4) && cnt < 40) begin
      alu_req_i = (ai < 4); alu_addr_i = RAW'(8 + ai);  alu_data_i = DW'(8'hA0 + ai);
      ld_req_i  = (li < 4); ld_addr_i  = RAW'(12 + li); ld_data_i  = DW'(8'hC0 + li);
      ga = alu_gnt_o; gl = ld_gnt_o;
      both_low = !ga && !gl;
      chk("t5_gnt_live", prev_low && both_low, 0);
      prev_low = both_low;
      tick();
      if (alu_req_i && ga) ai++;
      if (ld_req_i && gl)  li++;
      cnt++;
    end
    chk("t5_accept_bound", (cnt < 40), 1);
    idle_inputs();
    repeat (6) tick();
    chk("t5_n", wq.size(), 8);
    for (int j = 0; j < 8; j++) begin
      k = j / 2;
      exp_w = (j % 2 == 0) ? {RAW'(8 + k), DW'(8'hA0 + k)} : {RAW'(12 + k), DW'(8'hC0 + k)};
      chk($sformatf("t5_w%0d", j), wq[j], exp_w);
      chk($sformatf("t5_c%0d", j), wc[j] - wc[0], j);
    end

    // Asynchronous reset while both slots hold entries and a write is on the port
    clear_q();
    alu_req_i = 1; alu_addr_i = 4'd1; alu_data_i = 8'h33;
    ld_req_i  = 1; ld_addr_i  = 4'd6; ld_data_i  = 8'h44;
    tick();
    ld_req_i = 0;
    alu_addr_i = 4'd9; alu_data_i = 8'h55;
    tick();
    idle_inputs();
    chk("t6_pre_wen",  wen_o,   1);
    chk("t6_pre_busy", busy_o,  32'h0242);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_wen",   wen_o,   0);
    chk("t6_waddr", waddr_o, 0);
    chk("t6_wdata", wdata_o, 0);
    chk("t6_busy",  busy_o,  0);
    chk("t6_idle",  idle_o,  1);
    clear_q();
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("t6_nowr", wq.size(), 0);
    alu_req_i = 1; alu_addr_i = 4'd2; alu_data_i = 8'h66;
    ld_req_i  = 1; ld_addr_i  = 4'd3; ld_data_i  = 8'h77;
    tick();
    idle_inputs();
    repeat (3) tick();
    chk("t6_n",  wq.size(), 2);
    chk("t6_w0", wq[0], {4'd2, 8'h66});
    chk("t6_w1", wq[1], {4'd3, 8'h77});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single synchronous write port between two writeback sources: ALU result (ALU) and memory load return (LD).
- Each source has a one-entry holding slot with a req/gnt handshake.
- A round-robin arbiter drains the slots onto a registered write port, with same-address ordering protection.
- Exports a per-register busy vector so the decoder stalls reads of registers with a write still in flight.

Parameters:
- RAW, 4, register file address width; 2**RAW registers.
- DW, 8, data width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset; asynchronous, active-low.
- alu_req_i  input  1  ALU requests a writeback this cycle.
- alu_addr_i  input  RAW  ALU destination register.
- alu_data_i  input  DW  ALU write data.
- alu_gnt_o  output  1  ALU slot can accept; transfer occurs when alu_req_i & alu_gnt_o.
- ld_req_i  input  1  LD requests a writeback.
- ld_addr_i  input  RAW  LD destination register.
- ld_data_i  input  DW  LD write data.
- ld_gnt_o  output  1  LD slot can accept; transfer occurs when ld_req_i & ld_gnt_o.
- wen_o  output  1  write enable to register file (registered).
- waddr_o  output  RAW  write address to register file (registered).
- wdata_o  output  DW  write data to register file (registered).
- busy_o  output  2**RAW  bit a set: a write to register a is pending.
- idle_o  output  1  no slot valid and wen_o low.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Both slots invalid; wen_o=0, waddr_o=0, wdata_o=0.
  - last_winner=LD; age flag cleared.
  - busy_o=0, idle_o=1.
  - Pending writes are discarded, including when reset asserts mid-operation.
- Accept: at a posedge where req & gnt, the slot captures {addr, data} and sets valid.
- Grant: gnt = !slot_valid | slot_granted_this_cycle. This gives back-to-back throughput of 1 per source per cycle when that source is winning. gnt does not depend on req_i, so there is no combinational loop.
- Arbitration (combinational, among valid slots, each cycle):
  - Only one valid: that slot wins.
  - Both valid, addresses differ: round-robin; the winner is the source that is not last_winner.
  - Both valid, same address: the older slot wins, tracked by an age flag set at accept. If both were accepted on the same edge, ALU wins first.
  - last_winner updates only when a grant occurs.
- Issue: at the posedge after arbitration:
  - wen_o<=1, waddr_o/wdata_o<=winner contents, winner slot invalidated, unless the same source refills it on that same edge.
  - With no winner, wen_o<=0 and waddr_o/wdata_o hold their values.
- Latency: accept edge E0 -> wen_o high during cycle after E1 -> register file commits at E2. Minimum 2 edges; worst case 3 edges under contention.
- busy_o[a] = (alu_v & alu_addr==a) | (ld_v & ld_addr==a) | (wen_o & waddr_o==a).
  - Combinational from state only; it does not include this cycle's incoming req.
- Same-address ordering: the register file must observe writes in acceptance order, ALU before LD on a same-edge tie.
- Register 1 (RS) receives no special treatment.
- Sustained throughput: one register file write per cycle with both sources saturated.

Decomposition:
- Package rf_arb_pkg:
  - RAW, DW defaults.
  - typedefs rf_addr_t, rf_data_t.
  - struct wr_req_t {addr, data}.
  - enum src_e {SRC_ALU, SRC_LD}.
- Sub-module rf_wr_slot: one-entry holding register with valid, load, clear, and simultaneous clear+load. Instantiated twice.
- Arbiter, age flag, output stage and busy decode live in the top module.

Test Plan:
- Reset then ALU req addr=3 data=0x5A at E0:
  - wen_o=1, waddr_o=3, wdata_o=0x5A in the cycle after E1.
  - busy_o[3]=1 from E0 until wen_o drops.
  - idle_o=1 afterwards.
- Same-edge ALU addr=2 data=0x11 and LD addr=5 data=0x22:
  - Issue ALU then LD on consecutive cycles.
  - Repeat the same pattern: issue LD then ALU (round-robin alternates).
- Same-address race: LD addr=4 data=0xAA at E0, ALU addr=4 data=0xBB at E1:
  - Write sequence 0xAA then 0xBB to reg 4.
  - A modelled register file ends with 0xBB.
- Same-edge ALU/LD both addr=7, ALU=0x01, LD=0x02 -> ALU first; final reg 7 = 0x02.
- Both sources req every cycle for 8 cycles:
  - Gnts never both drop for two consecutive cycles.
  - 8 writes issue back-to-back with no loss or duplication; the scoreboard matches.
- rst_n pulsed low mid-cycle while both slots are valid and wen_o=1:
  - Outputs clear immediately (asynchronous), busy_o=0, no further writes.
  - The first post-reset tie grants ALU.
